// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : CPU data-bus request group (address and read/write strobes)
//               shared by the CPU (master) and the data-memory responder
//               (slave). The bidirectional data bus DDB is a separate port
//               on the responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
  logic [63:0] DAB;
  logic        MemRead;
  logic        MemWrite;

  modport master (output DAB, output MemRead, output MemWrite);
  modport slave  (input  DAB, input  MemRead, input  MemWrite);
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder for the single-cycle CPU. Serves
//               combinational reads on DDB and posts writes into a one-entry
//               buffer that drains into the word array on the next edge.
//               Reads of the buffered word are forwarded from the buffer.
//               Illegal accesses are recorded in a sticky error register.
//               Optional feature macro: DMEM_STATS_EN (read/write counters).
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int          DEPTH = 256,
  parameter logic [63:0] BASE  = 64'h0
) (
  input  wire                    clk,
  input  wire                    rst_n,
  dmem_responder_if.slave        bus,
  inout  wire  [63:0]            DDB,
  input  wire                    err_clr,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic [63:0]            err_addr,
  output logic [31:0]            rd_cnt,
  output logic [31:0]            wr_cnt
);

  localparam int         c_IDX_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] c_ERR_NONE     = 2'b00;
  localparam logic [1:0] c_ERR_MISALIGN = 2'b01;
  localparam logic [1:0] c_ERR_RANGE    = 2'b10;
  localparam logic [1:0] c_ERR_CONFLICT = 2'b11;

  // Storage array; intentionally not reset.
  logic [63:0]        r_mem [DEPTH];

  // Posted write buffer.
  logic               r_buf_valid;
  logic [c_IDX_W-1:0] r_buf_idx;
  logic [63:0]        r_buf_data;

  // Address decode.
  logic [63:0]        w_offset;
  logic [63:0]        w_word;
  logic [c_IDX_W-1:0] w_idx;
  logic               w_in_range;
  logic               w_aligned;
  logic               w_conflict;
  logic               w_rd_legal;
  logic               w_wr_legal;
  logic               w_illegal;
  logic [1:0]         w_code;
  logic [63:0]        w_rd_data;

  assign w_offset   = bus.DAB - BASE;
  assign w_word     = w_offset >> 3;
  assign w_idx      = w_word[c_IDX_W-1:0];
  assign w_in_range = (bus.DAB >= BASE) && (w_word < 64'(DEPTH));
  assign w_aligned  = (bus.DAB[2:0] == 3'b000);
  assign w_conflict = bus.MemRead & bus.MemWrite;
  assign w_rd_legal = bus.MemRead  & ~bus.MemWrite & w_in_range & w_aligned;
  assign w_wr_legal = bus.MemWrite & ~bus.MemRead  & w_in_range & w_aligned;
  assign w_illegal  = (bus.MemRead | bus.MemWrite) & ~(w_rd_legal | w_wr_legal);

  // Classify the fault with priority conflict > out of range > misaligned.
  always_comb begin
    w_code = c_ERR_NONE;
    if (w_conflict)
      w_code = c_ERR_CONFLICT;
    else if (!w_in_range)
      w_code = c_ERR_RANGE;
    else if (!w_aligned)
      w_code = c_ERR_MISALIGN;
  end

  // Read mux: the buffered word is newer than the array copy.
  always_comb begin
    w_rd_data = r_mem[w_idx];
    if (r_buf_valid && (r_buf_idx == w_idx))
      w_rd_data = r_buf_data;
  end

  // DDB is driven only for a legal read outside reset.
  assign DDB = (w_rd_legal && rst_n) ? w_rd_data : {64{1'bz}};

  // Capture a legal write into the buffer; otherwise the buffer empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_valid <= 1'b0;
      r_buf_idx   <= '0;
      r_buf_data  <= '0;
    end else if (w_wr_legal) begin
      r_buf_valid <= 1'b1;
      r_buf_idx   <= w_idx;
      r_buf_data  <= DDB;
    end else begin
      r_buf_valid <= 1'b0;
    end
  end

  // Drain the buffered word into the array on every edge it is valid.
  always_ff @(posedge clk) begin
    if (r_buf_valid)
      r_mem[r_buf_idx] <= r_buf_data;
  end

  // Sticky error register; a clear coinciding with a new fault loads the fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err      <= 1'b0;
      err_code <= c_ERR_NONE;
      err_addr <= '0;
    end else if (w_illegal && (err_clr || !err)) begin
      err      <= 1'b1;
      err_code <= w_code;
      err_addr <= bus.DAB;
    end else if (err_clr) begin
      err      <= 1'b0;
      err_code <= c_ERR_NONE;
      err_addr <= '0;
    end
  end

`ifdef DMEM_STATS_EN
  logic [31:0] r_rd_cnt;
  logic [31:0] r_wr_cnt;

  // Free-running wrap-around counters of legal reads and writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_rd_legal)
        r_rd_cnt <= r_rd_cnt + 32'd1;
      if (w_wr_legal)
        r_wr_cnt <= r_wr_cnt + 32'd1;
    end
  end

  assign rd_cnt = r_rd_cnt;
  assign wr_cnt = r_wr_cnt;
`else
  assign rd_cnt = '0;
  assign wr_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. A pull-up on DDB
//               makes an undriven bus read as all ones.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int          c_DEPTH = 16;
  localparam logic [63:0] c_BASE  = 64'h1000;
  localparam logic [63:0] c_Z     = {64{1'b1}};

  localparam logic [1:0] c_CHK_NONE = 2'd0;
  localparam logic [1:0] c_CHK_VAL  = 2'd1;
  localparam logic [1:0] c_CHK_Z    = 2'd2;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        clr;
    logic [1:0]  chk_ddb;
    logic [63:0] exp_ddb;
    logic        exp_err;
    logic [1:0]  exp_code;
    logic [63:0] exp_addr;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        err_clr;
  logic        err;
  logic [1:0]  err_code;
  logic [63:0] err_addr;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  wire  [63:0] DDB;
  logic        tb_drv;
  logic [63:0] tb_data;

  int n_tests;
  int n_fail;

  dmem_responder_if bus ();

  pullup (DDB);
  assign DDB = tb_drv ? tb_data : {64{1'bz}};

  dmem_responder #(.DEPTH(c_DEPTH), .BASE(c_BASE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .DDB      (DDB),
    .err_clr  (err_clr),
    .err      (err),
    .err_code (err_code),
    .err_addr (err_addr),
    .rd_cnt   (rd_cnt),
    .wr_cnt   (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] a(input int i);
    return c_BASE + 64'(8 * i);
  endfunction

  function automatic logic [31:0] cnt_exp(input int n);
`ifdef DMEM_STATS_EN
    return 32'(n);
`else
    return 32'(n) & 32'h0;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic clr,
                              input logic [1:0] chk, input logic [63:0] exp_ddb,
                              input logic e, input logic [1:0] code, input logic [63:0] eaddr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.clr = clr;
    v.chk_ddb = chk; v.exp_ddb = exp_ddb;
    v.exp_err = e; v.exp_code = code; v.exp_addr = eaddr;
    return v;
  endfunction

  // One bus cycle: drive at posedge+1, sample DDB mid-cycle, sample errors after the edge.
  task automatic apply(input vec_t v, input string tag);
    bus.DAB      = v.addr;
    bus.MemRead  = v.rd;
    bus.MemWrite = v.wr;
    err_clr      = v.clr;
    tb_data      = v.wdata;
    tb_drv       = v.wr & ~v.rd;
    #4;
    if (v.chk_ddb == c_CHK_VAL) check({tag, ".ddb"}, DDB, v.exp_ddb);
    else if (v.chk_ddb == c_CHK_Z) check({tag, ".ddb_z"}, DDB, c_Z);
    @(posedge clk);
    #1;
    check({tag, ".err"},      64'(err),      64'(v.exp_err));
    check({tag, ".err_code"}, 64'(err_code), 64'(v.exp_code));
    check({tag, ".err_addr"}, err_addr,      v.exp_addr);
  endtask

  vec_t vecs [$];
  vec_t v;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    err_clr = 1'b0;
    tb_drv  = 1'b0;
    tb_data = '0;
    bus.DAB      = a(1);
    bus.MemRead  = 1'b1;
    bus.MemWrite = 1'b0;

    // Reset state, including a read request held during reset.
    #12;
    check("rst.err",      64'(err),      64'd0);
    check("rst.err_code", 64'(err_code), 64'd0);
    check("rst.err_addr", err_addr,      64'd0);
    check("rst.rd_cnt",   64'(rd_cnt),   64'd0);
    check("rst.wr_cnt",   64'(wr_cnt),   64'd0);
    check("rst.ddb_z",    DDB,           c_Z);
    bus.MemRead = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    //          rd    wr    addr         wdata                   clr   chk         exp_ddb                 err   code   eaddr
    vecs.push_back(mk(1'b0, 1'b1, a(0),        64'h1111_0000_0000_0000, 1'b0, c_CHK_NONE, 64'h0,                  1'b0, 2'b00, 64'h0));
    vecs.push_back(mk(1'b0, 1'b1, a(15),       64'h0F0F_0000_0000_000F, 1'b0, c_CHK_NONE, 64'h0,                  1'b0, 2'b00, 64'h0));
    vecs.push_back(mk(1'b0, 1'b1, a(3),        64'h0303_0303_0303_0303, 1'b0, c_CHK_NONE, 64'h0,                  1'b0, 2'b00, 64'h0));
    vecs.push_back(mk(1'b0, 1'b1, a(1),        64'hDEAD_BEEF_0123_4567, 1'b0, c_CHK_NONE, 64'h0,                  1'b0, 2'b00, 64'h0));
    vecs.push_back(mk(1'b1, 1'b0, a(1),        64'h0,                   1'b0, c_CHK_VAL,  64'hDEAD_BEEF_0123_4567, 1'b0, 2'b00, 64'h0));
    vecs.push_back(mk(1'b0, 1'b0, a(0),        64'h0,                   1'b0, c_CHK_Z,    64'h0,                  1'b0, 2'b00, 64'h0));
    vecs.push_back(mk(1'b1, 1'b0, a(1),        64'h0,                   1'b0, c_CHK_VAL,  64'hDEAD_BEEF_0123_4567, 1'b0, 2'b00, 64'h0));
    vecs.push_back(mk(1'b0, 1'b1, a(2),        64'hA5A5_A5A5_0000_0002, 1'b0, c_CHK_NONE, 64'h0,                  1'b0, 2'b00, 64'h0));
    vecs.push_back(mk(1'b0, 1'b1, a(2),        64'h5B5B_0000_0000_0B0B, 1'b0, c_CHK_NONE, 64'h0,                  1'b0, 2'b00, 64'h0));
    vecs.push_back(mk(1'b1, 1'b0, a(2),        64'h0,                   1'b0, c_CHK_VAL,  64'h5B5B_0000_0000_0B0B, 1'b0, 2'b00, 64'h0));
    vecs.push_back(mk(1'b0, 1'b0, a(0),        64'h0,                   1'b0, c_CHK_NONE, 64'h0,                  1'b0, 2'b00, 64'h0));
    vecs.push_back(mk(1'b1, 1'b0, a(2),        64'h0,                   1'b0, c_CHK_VAL,  64'h5B5B_0000_0000_0B0B, 1'b0, 2'b00, 64'h0));
    vecs.push_back(mk(1'b1, 1'b0, a(0),        64'h0,                   1'b0, c_CHK_VAL,  64'h1111_0000_0000_0000, 1'b0, 2'b00, 64'h0));
    vecs.push_back(mk(1'b1, 1'b0, a(15),       64'h0,                   1'b0, c_CHK_VAL,  64'h0F0F_0000_0000_000F, 1'b0, 2'b00, 64'h0));
    vecs.push_back(mk(1'b1, 1'b0, c_BASE+4,    64'h0,                   1'b0, c_CHK_Z,    64'h0,                  1'b1, 2'b01, c_BASE+4));
    vecs.push_back(mk(1'b0, 1'b0, a(0),        64'h0,                   1'b1, c_CHK_NONE, 64'h0,                  1'b0, 2'b00, 64'h0));
    vecs.push_back(mk(1'b0, 1'b1, a(c_DEPTH),  64'h0000_0000_0000_BAD0, 1'b0, c_CHK_NONE, 64'h0,                  1'b1, 2'b10, a(c_DEPTH)));
    vecs.push_back(mk(1'b1, 1'b0, c_BASE+3,    64'h0,                   1'b0, c_CHK_Z,    64'h0,                  1'b1, 2'b10, a(c_DEPTH)));
    vecs.push_back(mk(1'b1, 1'b0, a(0),        64'h0,                   1'b0, c_CHK_VAL,  64'h1111_0000_0000_0000, 1'b1, 2'b10, a(c_DEPTH)));
    vecs.push_back(mk(1'b1, 1'b0, a(15),       64'h0,                   1'b0, c_CHK_VAL,  64'h0F0F_0000_0000_000F, 1'b1, 2'b10, a(c_DEPTH)));
    vecs.push_back(mk(1'b1, 1'b1, a(0),        64'h0,                   1'b1, c_CHK_Z,    64'h0,                  1'b1, 2'b11, c_BASE));
    vecs.push_back(mk(1'b1, 1'b0, a(0),        64'h0,                   1'b0, c_CHK_VAL,  64'h1111_0000_0000_0000, 1'b1, 2'b11, c_BASE));
    vecs.push_back(mk(1'b0, 1'b0, a(0),        64'h0,                   1'b1, c_CHK_NONE, 64'h0,                  1'b0, 2'b00, 64'h0));
    vecs.push_back(mk(1'b1, 1'b0, c_BASE-8,    64'h0,                   1'b0, c_CHK_Z,    64'h0,                  1'b1, 2'b10, c_BASE-8));
    vecs.push_back(mk(1'b0, 1'b0, a(0),        64'h0,                   1'b1, c_CHK_NONE, 64'h0,                  1'b0, 2'b00, 64'h0));

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // 9 legal reads and 6 legal writes in the table above.
    check("tbl.rd_cnt", 64'(rd_cnt), 64'(cnt_exp(9)));
    check("tbl.wr_cnt", 64'(wr_cnt), 64'(cnt_exp(6)));

    // Reset right after a write edge, with a sticky error pending.
    apply(mk(1'b1, 1'b0, c_BASE+1, 64'h0, 1'b0, c_CHK_Z, 64'h0, 1'b1, 2'b01, c_BASE+1), "pre_rst");
    bus.DAB      = a(3);
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b1;
    tb_data      = 64'h3333_0000_0000_0033;
    tb_drv       = 1'b1;
    @(posedge clk);
    #2;
    rst_n        = 1'b0;
    bus.MemWrite = 1'b0;
    tb_drv       = 1'b0;
    #1;
    check("arst.err",      64'(err),      64'd0);
    check("arst.err_code", 64'(err_code), 64'd0);
    check("arst.err_addr", err_addr,      64'd0);
    check("arst.rd_cnt",   64'(rd_cnt),   64'd0);
    check("arst.wr_cnt",   64'(wr_cnt),   64'd0);
    bus.MemRead = 1'b1;
    #1;
    check("arst.ddb_z", DDB, c_Z);
    bus.MemRead = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // The lost buffered write must not appear in the array; then 3 reads, 2 writes.
    apply(mk(1'b1, 1'b0, a(3), 64'h0, 1'b0, c_CHK_VAL, 64'h0303_0303_0303_0303, 1'b0, 2'b00, 64'h0), "post0");
    apply(mk(1'b0, 1'b1, a(4), 64'h4444_0000_0000_0004, 1'b0, c_CHK_NONE, 64'h0, 1'b0, 2'b00, 64'h0), "post1");
    apply(mk(1'b0, 1'b1, a(5), 64'h5555_0000_0000_0005, 1'b0, c_CHK_NONE, 64'h0, 1'b0, 2'b00, 64'h0), "post2");
    apply(mk(1'b1, 1'b0, a(4), 64'h0, 1'b0, c_CHK_VAL, 64'h4444_0000_0000_0004, 1'b0, 2'b00, 64'h0), "post3");
    apply(mk(1'b1, 1'b0, a(5), 64'h0, 1'b0, c_CHK_VAL, 64'h5555_0000_0000_0005, 1'b0, 2'b00, 64'h0), "post4");
    check("post.rd_cnt", 64'(rd_cnt), 64'(cnt_exp(3)));
    check("post.wr_cnt", 64'(wr_cnt), 64'(cnt_exp(2)));

    v = mk(1'b0, 1'b0, a(0), 64'h0, 1'b0, c_CHK_Z, 64'h0, 1'b0, 2'b00, 64'h0);
    apply(v, "idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
